// File: rtl/axil_ram_ext_if.sv
// AXI4-Lite bus bundle for the axil_ram_ext scratchpad memory.
// The master side drives requests; the slave side returns ready and response signals.
interface axil_ram_ext_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_ram_ext.sv
// AXI4-Lite slave RAM: independent AW/W capture, arbitrary depth with SLVERR beyond it,
// read-first memory and an optional extra register stage on the R channel.
module axil_ram_ext #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int DEPTH           = 2 ** (ADDR_WIDTH - $clog2(STRB_WIDTH)),
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic          clk,
  input  logic          rst,
  axil_ram_ext_if.slave s_axil
);

  localparam int OFFS_W = $clog2(STRB_WIDTH);
  localparam int IDX_W  = ADDR_WIDTH - OFFS_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:OFFS_W];
  endfunction

  function automatic logic in_range(input idx_t idx);
    return {1'b0, idx} < DEPTH_L;
  endfunction

  function automatic logic [MEM_AW-1:0] mem_addr(input idx_t idx);
    return idx[MEM_AW-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Protection bits and sub-word address bits carry no meaning for this memory.
  logic unused_ok;
  assign unused_ok = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr, s_axil.araddr};

  // ---------------- write path: beat holding and commit ----------------
  logic                  aw_held;
  logic                  w_held;
  idx_t                  aw_idx;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  commit;
  logic                  wr_en;

  assign s_axil.awready = !aw_held && !rst;
  assign s_axil.wready  = !w_held && !rst;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;

  assign aw_fire = s_axil.awvalid && s_axil.awready;
  assign w_fire  = s_axil.wvalid && s_axil.wready;
  // A new response may only be produced once the previous one is leaving.
  assign commit  = aw_held && w_held && (!bvalid_q || s_axil.bready);
  assign wr_en   = commit && !rst && in_range(aw_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (commit)       aw_held <= 1'b0;
      else if (aw_fire) aw_held <= 1'b1;

      if (commit)      w_held <= 1'b0;
      else if (w_fire) w_held <= 1'b1;

      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= in_range(aw_idx) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_fire) aw_idx <= word_idx(s_axil.awaddr);
    if (w_fire) begin
      wdata_q <= s_axil.wdata;
      wstrb_q <= s_axil.wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb_q[i]) mem[mem_addr(aw_idx)][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // ---------------- read path p1: address hold and memory read ----------------
  logic                  ar_held;
  idx_t                  ar_idx;
  logic                  ar_fire;
  logic                  issue;
  logic                  p1_free;
  logic                  p1_take;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] rdata_p1;
  logic [1:0]            rresp_p1;

  assign s_axil.arready = !ar_held && !rst;
  assign ar_fire        = s_axil.arvalid && s_axil.arready;
  assign issue          = ar_held && p1_free;

  always_ff @(posedge clk) begin
    if (ar_fire) ar_idx <= word_idx(s_axil.araddr);
  end

  // The memory write above lands on the same edge, so a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_held  <= 1'b0;
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      rresp_p1 <= RESP_OKAY;
    end else begin
      if (issue)        ar_held <= 1'b0;
      else if (ar_fire) ar_held <= 1'b1;

      if (issue) begin
        vld_p1 <= 1'b1;
        if (in_range(ar_idx)) begin
          rdata_p1 <= mem[mem_addr(ar_idx)];
          rresp_p1 <= RESP_OKAY;
        end else begin
          rdata_p1 <= '0;
          rresp_p1 <= RESP_SLVERR;
        end
      end else if (p1_take) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // ---------------- read path p2: optional output register ----------------
  if (PIPELINE_OUTPUT != 0) begin : g_pipe
    logic                  vld_p2;
    logic [DATA_WIDTH-1:0] rdata_p2;
    logic [1:0]            rresp_p2;
    logic                  p2_load;

    assign p2_load = !vld_p2 || s_axil.rready;
    assign p1_take = vld_p1 && p2_load;
    assign p1_free = !vld_p1 || p2_load;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p2   <= 1'b0;
        rdata_p2 <= '0;
        rresp_p2 <= RESP_OKAY;
      end else if (p2_load) begin
        vld_p2   <= vld_p1;
        rdata_p2 <= rdata_p1;
        rresp_p2 <= rresp_p1;
      end
    end

    assign s_axil.rvalid = vld_p2;
    assign s_axil.rdata  = rdata_p2;
    assign s_axil.rresp  = rresp_p2;
  end else begin : g_direct
    assign p1_take = vld_p1 && s_axil.rready;
    assign p1_free = !vld_p1 || s_axil.rready;

    assign s_axil.rvalid = vld_p1;
    assign s_axil.rdata  = rdata_p1;
    assign s_axil.rresp  = rresp_p1;
  end

endmodule
